pipeline_hazard_ctrl: RTL

//  Control end of the pipeline-register interface: watches ID and EX stage fields and drives

---
 rtl/risc_v_pipeline_pkg.sv | 12 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/risc_v_pipeline_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control blocks.
package risc_v_pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_LOAD_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter sharing the pipeline's falling-edge register timing.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline-register enable/flush control: load-use stalls, taken-branch flushes,
// data-memory freezes, plus stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import risc_v_pipeline_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic                  mem_timeout
);

    localparam logic [2:0] BUBBLE_LOAD = 3'(LOAD_USE_BUBBLES - 1);
    localparam logic [7:0] TMO_LAST    = 8'(MEM_TIMEOUT - 1);

    hz_state_e  state, state_nxt;
    logic [2:0] bub_cnt, bub_nxt;
    logic [7:0] wait_cnt;
    logic       hazard;

    always_comb begin
        hazard = ex_mem_read && (ex_rd != X0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        state_nxt   = state;
        bub_nxt     = bub_cnt;

        if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = ST_RUN;
            bub_nxt     = '0;
        end else if (state == ST_LOAD_STALL) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            bub_nxt     = bub_cnt - 1'b1;
            if (bub_cnt == 3'd1) begin
                state_nxt = ST_RUN;
            end
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            // The first bubble is this cycle; only extra bubbles need the stall state.
            if (LOAD_USE_BUBBLES > 1) begin
                state_nxt = ST_LOAD_STALL;
                bub_nxt   = BUBBLE_LOAD;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            bub_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
        end
    end

    // wait_cnt parks at TMO_LAST so long freezes cannot wrap it.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            if (wait_cnt == TMO_LAST) begin
                mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!mem_busy && ex_branch_taken),
        .count (flush_events)
    );

endmodule
